// File: rtl/radix4_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_seq_divider
//  Purpose  : Sequential unsigned radix-4 restoring divider. Divides a 2N-bit
//             dividend by an N-bit divisor and retires two quotient bits per
//             clock, so a normal division takes N/2 CALC cycles.
//  Ports    :
//     clk          in   1    rising-edge clock
//     rst_n        in   1    asynchronous active-low reset
//     in_valid     in   1    dividend/divisor valid
//     in_ready     out  1    operation can be accepted (IDLE only)
//     dividend     in   2N   unsigned dividend
//     divisor      in   N    unsigned divisor
//     out_valid    out  1    result valid, held until out_ready
//     out_ready    in   1    consumer accepts result
//     quotient     out  N    unsigned quotient
//     remainder    out  N    unsigned remainder
//     div_by_zero  out  1    divisor was zero
//     overflow     out  1    quotient does not fit in N bits
//  Revision : 1.0  initial release
// ============================================================================
module radix4_seq_divider #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int c_steps = N / 2;
    localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(c_steps - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Partial remainder. Because R < D holds after every step its value
    // always fits in N bits, so only the low N bits are kept.
    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_d;
    logic [N+1:0]       r_d3;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dbz;
    logic               r_ovf;

    logic               w_accept;
    logic               w_exc_dbz;
    logic               w_exc_ovf;
    logic [N+1:0]       w_t;
    logic [N+1:0]       w_d1;
    logic [N+1:0]       w_d2;
    logic [1:0]         w_digit;
    logic [N-1:0]       w_sub;
    logic [N-1:0]       w_r_next;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_exc_dbz = (divisor == '0);
    assign w_exc_ovf = (dividend[2*N-1:N] >= divisor);

    // Shift two dividend bits into the partial remainder.
    assign w_t  = {r_rem, r_q[N-1:N-2]};
    assign w_d1 = {2'b00, r_d};
    assign w_d2 = {1'b0, r_d, 1'b0};

    // Digit selection compares at full N+2 width; the subtraction itself can
    // be done modulo 2^N because the true difference is below D < 2^N.
    always_comb begin
        w_digit = 2'd0;
        w_sub   = '0;
        if (w_t >= r_d3) begin
            w_digit = 2'd3;
            w_sub   = r_d3[N-1:0];
        end else if (w_t >= w_d2) begin
            w_digit = 2'd2;
            w_sub   = {r_d[N-2:0], 1'b0};
        end else if (w_t >= w_d1) begin
            w_digit = 2'd1;
            w_sub   = r_d;
        end
    end

    assign w_r_next = w_t[N-1:0] - w_sub;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = (w_exc_dbz || w_exc_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == c_last_step) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_d3  <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_exc_dbz) begin
                r_q   <= '1;
                r_rem <= dividend[N-1:0];
                r_dbz <= 1'b1;
                r_ovf <= 1'b0;
            end else if (w_exc_ovf) begin
                r_q   <= '1;
                r_rem <= '0;
                r_dbz <= 1'b0;
                r_ovf <= 1'b1;
            end else begin
                r_q   <= dividend[N-1:0];
                r_rem <= dividend[2*N-1:N];
                r_d   <= divisor;
                r_d3  <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
                r_dbz <= 1'b0;
                r_ovf <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_r_next;
            r_q   <= {r_q[N-3:0], w_digit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire
